// File: rtl/tcm_sram_port_ctrl.sv
// Valid/ready request front-end for one port of the OpenRAM TCM macro.
// Registered accept stage plus a small in-order response FIFO.
module tcm_sram_port_ctrl #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 64,
  parameter int          NUM_WMASKS = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          TAG_WIDTH  = 4,
  parameter int          RESP_DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_wr_i,
  input  logic [NUM_WMASKS-1:0] req_wstrb_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_wr_o,
  output logic                  resp_err_o,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W     = $clog2(RESP_DEPTH);
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);

  logic                  r_live;
  logic                  r_inflight;
  logic [TAG_WIDTH-1:0]  r_stg_tag;
  logic                  r_stg_wr;
  logic                  r_stg_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [DATA_WIDTH-1:0] r_fifo_data [RESP_DEPTH];
  logic [TAG_WIDTH-1:0]  r_fifo_tag  [RESP_DEPTH];
  logic                  r_fifo_wr   [RESP_DEPTH];
  logic                  r_fifo_err  [RESP_DEPTH];

  logic [31:0]           w_off;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [CNT_W:0]        w_occ;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [PTR_W-1:0]      w_wptr_nxt;
  logic [PTR_W-1:0]      w_rptr_nxt;

  // An offset below BASE_ADDR wraps to a huge value and lands in the range error.
  assign w_off   = req_addr_i - BASE_ADDR;
  assign w_err   = (w_off[2:0] != 3'b000) | (w_off[31:3] >= 29'(RAM_DEPTH));
  assign w_waddr = w_off[ADDR_WIDTH+2:3];

  // Reserving a slot for the stage entry guarantees every push finds room.
  assign w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_ready  = r_live & (w_occ < DEPTH_C);
  assign w_accept = req_valid_i & w_ready;
  assign w_access = w_accept & ~w_err;

  assign req_ready_o = w_ready;

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = r_addr;
    sram_din_o   = r_din;
    if (w_access) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = ~req_wr_i;
      sram_wmask_o = req_wr_i ? req_wstrb_i : {NUM_WMASKS{1'b1}};
      sram_addr_o  = w_waddr;
      sram_din_o   = req_wdata_i;
    end
  end

  assign w_push      = r_inflight;
  assign w_pop       = (r_count != '0) & resp_ready_i;
  assign w_push_data = (~r_stg_wr & ~r_stg_err) ? sram_dout_i : '0;
  assign w_wptr_nxt  = (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt  = (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live     <= 1'b0;
      r_inflight <= 1'b0;
      r_stg_tag  <= '0;
      r_stg_wr   <= 1'b0;
      r_stg_err  <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_live     <= 1'b1;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_stg_tag <= req_tag_i;
        r_stg_wr  <= req_wr_i;
        r_stg_err <= w_err;
      end
      if (w_access) begin
        r_addr <= w_waddr;
        r_din  <= req_wdata_i;
      end
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_tag[i]  <= '0;
        r_fifo_wr[i]   <= 1'b0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_tag[r_wptr]  <= r_stg_tag;
      r_fifo_wr[r_wptr]   <= r_stg_wr;
      r_fifo_err[r_wptr]  <= r_stg_err;
    end
  end

  assign resp_valid_o = (r_count != '0);
  assign resp_data_o  = r_fifo_data[r_rptr];
  assign resp_tag_o   = r_fifo_tag[r_rptr];
  assign resp_wr_o    = r_fifo_wr[r_rptr];
  assign resp_err_o   = r_fifo_err[r_rptr];

endmodule

// File: tb/tb_tcm_sram_port_ctrl.sv
// Bench for tcm_sram_port_ctrl: behavioural SRAM, transaction-level scoreboard,
// directed scenarios followed by a randomized phase.
module tb_tcm_sram_port_ctrl;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_wr_i;
  logic [7:0]  req_wstrb_i;
  logic [63:0] req_wdata_i;
  logic [3:0]  req_tag_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic        resp_wr_o;
  logic        resp_err_o;
  logic [3:0]  resp_tag_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic [7:0]  sram_wmask_o;
  logic [4:0]  sram_addr_o;
  logic [63:0] sram_din_o;
  logic [63:0] sram_dout_i;

  always #5 clk = ~clk;

  tcm_sram_port_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(64), .NUM_WMASKS(8),
    .BASE_ADDR(BASE), .TAG_WIDTH(4), .RESP_DEPTH(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wr_i(req_wr_i),
    .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_wr_o(resp_wr_o),
    .resp_err_o(resp_err_o), .resp_tag_o(resp_tag_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o),
    .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
  );

  // Behavioural macro port: pins registered at posedge, read data valid next cycle.
  logic [63:0] sram_mem [DEPTH];
  logic [63:0] sram_tmp;
  always @(posedge clk) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        sram_tmp = sram_mem[sram_addr_o];
        for (int b = 0; b < 8; b++)
          if (sram_wmask_o[b]) sram_tmp[8*b +: 8] = sram_din_o[8*b +: 8];
        sram_mem[sram_addr_o] <= sram_tmp;
      end else begin
        sram_dout_i <= sram_mem[sram_addr_o];
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        wr;
    logic        err;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_log[$];
  logic [63:0] ref_mem [DEPTH];
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  logic [63:0] last_data;
  logic        last_wr, last_err;
  logic [3:0]  last_tag;
  logic        hold_prev = 1'b0;
  logic [63:0] hold_data;
  logic        hold_wr, hold_err;
  logic [3:0]  hold_tag;

  // Transaction monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] off;
    logic        aerr;
    int          w;
    cyc++;
    if (!rst_ni) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", resp_valid_o, 1'b1);
        check("hold_data", resp_data_o, hold_data);
        check("hold_tag", resp_tag_o, hold_tag);
        check("hold_flags", {resp_wr_o, resp_err_o}, {hold_wr, hold_err});
      end
      if (resp_valid_o && resp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", resp_data_o, e.data);
          check("resp_tag", resp_tag_o, e.tag);
          check("resp_wr", resp_wr_o, e.wr);
          check("resp_err", resp_err_o, e.err);
          if (lat_chk) check("resp_latency", cyc - e.cyc, 2);
          last_data = resp_data_o;
          last_tag  = resp_tag_o;
          last_wr   = resp_wr_o;
          last_err  = resp_err_o;
        end
      end
      if (req_valid_i && req_ready_o) begin
        off  = req_addr_i - BASE;
        aerr = (off % 8 != 0) || ((off / 8) >= DEPTH);
        w    = int'(off / 8) % DEPTH;
        check("sram_csb", sram_csb_o, aerr);
        if (!aerr) begin
          check("sram_addr", sram_addr_o, w);
          check("sram_web", sram_web_o, !req_wr_i);
          check("sram_wmask", sram_wmask_o, req_wr_i ? req_wstrb_i : 8'hFF);
          if (req_wr_i) begin
            check("sram_din", sram_din_o, req_wdata_i);
            for (int b = 0; b < 8; b++)
              if (req_wstrb_i[b]) ref_mem[w][8*b +: 8] = req_wdata_i[8*b +: 8];
          end
        end
        e.data = (!req_wr_i && !aerr) ? ref_mem[w] : 64'h0;
        e.wr   = req_wr_i;
        e.err  = aerr;
        e.tag  = req_tag_i;
        e.cyc  = cyc;
        exp_q.push_back(e);
        acc_log.push_back(cyc);
      end
      hold_prev = resp_valid_o && !resp_ready_i;
      hold_data = resp_data_o;
      hold_tag  = resp_tag_o;
      hold_wr   = resp_wr_o;
      hold_err  = resp_err_o;
    end
  end

  // All stimulus tasks start just after a posedge and end on a posedge.
  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] s,
                       input logic [63:0] d, input logic [3:0] t);
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_addr_i  = a;
    req_wstrb_i = s;
    req_wdata_i = d;
    req_tag_i   = t;
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = req_ready_o;
      @(posedge clk);
      if (ok) break;
    end
    if (!ok) check("accept_timeout", ok, 1'b1);
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [7:0] s,
                      input logic [63:0] d, input logic [3:0] t);
    #1 drive(wr, a, s, d, t);
    wait_accept();
  endtask

  task automatic idle();
    #1 req_valid_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_wr_i     = 1'b0;
    req_addr_i   = '0;
    req_wstrb_i  = '0;
    req_wdata_i  = '0;
    req_tag_i    = '0;
    resp_ready_i = 1'b1;
    sram_dout_i  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = {$urandom, $urandom};
      ref_mem[i]  = sram_mem[i];
    end

    #1;
    check("rst_ready", req_ready_o, 1'b0);
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_resp_data", resp_data_o, 64'h0);
    check("rst_resp_flags", {resp_wr_o, resp_err_o, resp_tag_o}, 6'h0);
    check("rst_csb_web", {sram_csb_o, sram_web_o}, 2'b11);
    check("rst_wmask", sram_wmask_o, 8'h0);
    check("rst_addr", sram_addr_o, 5'h0);
    check("rst_din", sram_din_o, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    @(posedge clk);

    // Reset while a read is in its N+1 cycle.
    send(1'b0, 32'h08, 8'h00, 64'h0, 4'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_csb", sram_csb_o, 1'b1);
    check("midrst_ready", req_ready_o, 1'b0);
    check("midrst_resp_valid", resp_valid_o, 1'b0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("postrst_ready", req_ready_o, 1'b1);
    check("postrst_resp_valid", resp_valid_o, 1'b0);
    repeat (3) @(posedge clk);
    check("postrst_dropped", resp_valid_o, 1'b0);

    // Full write then read-after-write.
    lat_chk = 1'b1;
    send(1'b1, 32'h18, 8'hFF, 64'h1122334455667788, 4'd3);
    send(1'b0, 32'h18, 8'h00, 64'h0, 4'd4);
    idle();
    drain();
    lat_chk = 1'b0;
    check("raw_data", last_data, 64'h1122334455667788);
    check("raw_tag", last_tag, 4'd4);

    // Partial write.
    send(1'b1, 32'h18, 8'h0F, 64'hAAAA_AAAA_DEAD_BEEF, 4'd7);
    send(1'b0, 32'h18, 8'h00, 64'h0, 4'd8);
    idle();
    drain();
    check("partial_data", last_data, 64'h11223344DEADBEEF);

    // Misaligned and out-of-range.
    send(1'b0, 32'h104, 8'h00, 64'h0, 4'd5);
    send(1'b0, 32'h100, 8'h00, 64'h0, 4'd6);
    idle();
    drain();
    check("oor_err", last_err, 1'b1);
    check("oor_data", last_data, 64'h0);
    check("oor_tag", last_tag, 4'd6);

    // Zero-strobe write leaves memory unchanged.
    send(1'b1, 32'h20, 8'h00, 64'hFFFF_0000_FFFF_0000, 4'd9);
    send(1'b0, 32'h20, 8'h00, 64'h0, 4'd10);
    idle();
    drain();
    check("wstrb0_wr_data", last_data, sram_mem[4]);

    // Backpressure: only three accepted while responses are stalled.
    acc_log.delete();
    #1 resp_ready_i = 1'b0;
    send(1'b0, 32'h00, 8'h00, 64'h0, 4'd1);
    send(1'b0, 32'h08, 8'h00, 64'h0, 4'd2);
    send(1'b0, 32'h10, 8'h00, 64'h0, 4'd3);
    #1 drive(1'b0, 32'h18, 8'h00, 64'h0, 4'd4);
    repeat (4) begin
      @(negedge clk);
      check("full_ready", req_ready_o, 1'b0);
    end
    @(posedge clk);
    check("full_accepts", acc_log.size(), 3);
    #1 resp_ready_i = 1'b1;
    wait_accept();
    send(1'b0, 32'h20, 8'h00, 64'h0, 4'd5);
    idle();
    drain();
    check("bp_total_accepts", acc_log.size(), 5);

    // Streaming reads, one accept per cycle.
    acc_log.delete();
    lat_chk = 1'b1;
    for (int i = 0; i < 32; i++) send(1'b0, 32'(i * 8), 8'h00, 64'h0, 4'(i));
    idle();
    drain();
    lat_chk = 1'b0;
    check("stream_count", acc_log.size(), 32);
    if (acc_log.size() == 32) check("stream_span", acc_log[31] - acc_log[0], 31);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      #1;
      req_valid_i  = ($urandom_range(0, 3) != 0);
      req_wr_i     = $urandom_range(0, 1) == 1;
      req_addr_i   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 'h140))
                                                 : 32'($urandom_range(0, 31) * 8);
      req_wstrb_i  = 8'($urandom);
      req_wdata_i  = {$urandom, $urandom};
      req_tag_i    = 4'($urandom);
      resp_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk);
    end
    #1 resp_ready_i = 1'b1;
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tcm_sram_port_ctrl.md
Name: tcm_sram_port_ctrl

Overview:
Single-port initiator that drives one port (csb/web/wmask/addr/din/dout) of the dual-port OpenRAM TCM macro from a valid/ready request channel. It returns in-order responses through a small response FIFO, so the core-side load/store path can apply backpressure without losing SRAM read data. Two instances are used per TCM: one per macro port, for example instruction fetch and LSU.

Parameters:
ADDR_WIDTH, 5, SRAM word-address width; RAM_DEPTH = 1<<ADDR_WIDTH.
DATA_WIDTH, 64, SRAM word width in bits.
NUM_WMASKS, 8, byte-lane write-mask width (DATA_WIDTH/8).
BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0.
TAG_WIDTH, 4, opaque request tag returned with each response.
RESP_DEPTH, 3, response FIFO entries; minimum 2; 3 is required for 1 req/cycle throughput.

Ports:
clk_i  in  1  clock; SRAM clk0/clk1 is the same net.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when valid&ready.
req_addr_i  in  32  byte address.
req_wr_i  in  1  1=write, 0=read.
req_wstrb_i  in  NUM_WMASKS  byte enables for writes.
req_wdata_i  in  DATA_WIDTH  write data.
req_tag_i  in  TAG_WIDTH  request tag.
resp_valid_o  out  1  response valid.
resp_ready_i  in  1  response consumed when valid&ready.
resp_data_o  out  DATA_WIDTH  read data; 0 for writes and errors.
resp_wr_o  out  1  response belongs to a write.
resp_err_o  out  1  misaligned or out-of-range access.
resp_tag_o  out  TAG_WIDTH  tag of the request.
sram_csb_o  out  1  active-low chip select.
sram_web_o  out  1  active-low write enable.
sram_wmask_o  out  NUM_WMASKS  byte write mask.
sram_addr_o  out  ADDR_WIDTH  word address.
sram_din_o  out  DATA_WIDTH  write data.
sram_dout_i  in  DATA_WIDTH  read data from SRAM.

Behaviour:
- Reset (async, rst_ni=0):
  - req_ready_o=0, resp_valid_o=0, resp_* data/flags=0.
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
  - Inflight flag and FIFO pointers/count are cleared. Requests in flight at reset are dropped; no response is produced for them.
- Decode (combinational on req_*):
  - off = req_addr_i - BASE_ADDR.
  - err = (off[2:0]!=0) | (off[31:3] >= RAM_DEPTH).
  - Word address = off[ADDR_WIDTH+2:3].
- req_ready_o = rst released & (fifo_count + inflight < RESP_DEPTH). It uses registered state only; there is no combinational path from resp_ready_i.
- Cycle N (accept, no error):
  - SRAM pins are driven combinationally: csb=0, web=~req_wr_i, addr=word address, din=req_wdata_i.
  - wmask=req_wstrb_i for writes, all-ones for reads (wmask is don't-care on reads but driven deterministically).
- No accept, or accept with err=1: csb=1, web=1, wmask=0. addr and din hold their last values; no SRAM access occurs.
- Posedge ending N: the SRAM registers the pins. The controller sets inflight=1 and stores tag, wr and err in the stage register.
- Cycle N+1: SRAM dout is valid before the posedge ending N+1. At that edge the stage entry is pushed to the FIFO.
  - data = sram_dout_i for an ok read, else 0.
  - inflight clears unless a new request was accepted in N+1.
- Cycle N+2: resp_valid_o=1 with the head entry. Load-to-response latency is 2 cycles when the FIFO is empty.
- Writes still occupy a stage/FIFO slot and return resp_wr_o=1, data 0. wstrb=0 is a legal write: csb=0, wmask=0, memory unchanged, normal ack.
- Responses are strictly in acceptance order. resp_* is held stable while resp_valid_o & ~resp_ready_i.
- Simultaneous FIFO push and pop in one cycle: count is unchanged, and this is legal when full. The pop frees the slot for the next cycle's ready.
- Full FIFO: ready stays 0 and no SRAM access is issued. Data already in flight always has a reserved slot, so no data is ever lost.
- Back-to-back read-after-write to the same address on this port: the read returns the new data, because the write commits at the negedge of the write cycle.
- Address wrap: an offset below BASE_ADDR underflows to a large value and is flagged err.

Test Plan:
- Reset mid-read: accept a read, assert rst_ni=0 in N+1 -> no response, csb=1, ready=0 asynchronously; after release, ready=1 and count=0.
- Write addr 0x18 data 64'h1122334455667788 wstrb 8'hFF tag 3, then read 0x18 tag 4 -> write resp (wr=1, tag 3) at N+2; read resp data 64'h1122334455667788, tag 4, one cycle later.
- Partial write wstrb 8'h0F data 64'hAAAA_AAAA_DEAD_BEEF over 64'h1122334455667788, then read -> 64'h11223344DEADBEEF.
- Read 0x104 (misaligned) and 0x100 (word 32, out of range) with BASE_ADDR 0 -> csb never low; both responses err=1, data 0.
- Hold resp_ready_i=0 and issue 5 reads -> exactly 3 accepted (ready drops); release -> 3 in-order responses with stable data; remaining 2 are then accepted.
- Stream 32 reads with resp_ready_i=1 and RESP_DEPTH=3 -> one accept per cycle, 32 in-order responses, each 2 cycles after its accept.
